// File: rtl/fp_conv_pkg.sv
// ---------------------------------------------------------------------------
// fp_conv_pkg
// Shared types and constants for the 12-bit two's-complement to 8-bit
// floating-point conversion (sign, 3-bit exponent, 4-bit significand).
// Contents: controller state enum, word widths, saturation/renormalisation
// constants.
// ---------------------------------------------------------------------------
package fp_conv_pkg;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX    = 3'b111;
  localparam logic [SIG_W-1:0] SIG_SAT    = 4'b1111;
  localparam logic [SIG_W-1:0] SIG_RENORM = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_round_stage.sv
// ---------------------------------------------------------------------------
// fp_round_stage
// Combinational rounding step of the float conversion.
// Ports:
//   sig_i   [3:0] candidate significand (mag[10:7] after normalisation)
//   exp_i   [2:0] exponent after normalisation
//   fifth_i       first discarded bit (mag[6])
//   sat_i         input already saturated (-2048)
//   sig_o   [3:0] final significand
//   exp_o   [2:0] final exponent
//   ovf_o         result saturated to S=1111, E=111
// Configuration macro: FP_CONV_ROUND_EN
//   defined   -> round-to-nearest, half-up on fifth_i
//   undefined -> truncation, fifth_i ignored
// ---------------------------------------------------------------------------
module fp_round_stage
  import fp_conv_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic             fifth_i,
  input  logic             sat_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             ovf_o
);

`ifndef FP_CONV_ROUND_EN
  logic unused_fifth_s;
  assign unused_fifth_s = fifth_i;
`endif

  // Round (or truncate) the normalised value and apply saturation.
  always_comb begin
    sig_o = sig_i;
    exp_o = exp_i;
    ovf_o = sat_i;
`ifdef FP_CONV_ROUND_EN
    if (fifth_i) begin
      if (sig_i != SIG_SAT) begin
        sig_o = sig_i + 4'd1;
      end else if (exp_i != EXP_MAX) begin
        // Significand carry-out: renormalise into the next exponent.
        sig_o = SIG_RENORM;
        exp_o = exp_i + 3'd1;
      end else begin
        // Carry out of the largest exponent cannot be represented.
        ovf_o = 1'b1;
      end
    end else begin
      sig_o = sig_i;
    end
`endif
    if (ovf_o) begin
      sig_o = SIG_SAT;
      exp_o = EXP_MAX;
    end else begin
      ovf_o = 1'b0;
    end
  end

endmodule

// File: rtl/fp_convert_ctrl.sv
// ---------------------------------------------------------------------------
// fp_convert_ctrl
// Sequenced 12-bit two's-complement to 8-bit float converter with
// valid/ready handshakes on both sides.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_data  [11:0]   two's-complement sample
//   in_valid/in_ready input handshake (in_ready high only in IDLE)
//   out_sign          sign bit
//   out_exp  [2:0]    exponent
//   out_sig  [3:0]    significand
//   out_ovf           result saturated
//   out_valid/out_ready output handshake; result held until consumed
// Configuration macro: FP_CONV_ROUND_EN (selects rounding in fp_round_stage).
// ---------------------------------------------------------------------------
module fp_convert_ctrl
  import fp_conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [IN_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sat_q, sat_d;
  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [SIG_W-1:0]  out_sig_q, out_sig_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [SIG_W-1:0]  rnd_sig_s;
  logic [EXP_W-1:0]  rnd_exp_s;
  logic              rnd_ovf_s;
  logic [IN_W-1:0]   abs_s;

  // Two's-complement negation of 0x800 yields 0x800, flagged later by mag[11].
  assign abs_s = in_data[IN_W-1] ? (~in_data + 12'd1) : in_data;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

  fp_round_stage u_round (
    .sig_i   (mag_q[10:7]),
    .exp_i   (exp_q),
    .fifth_i (mag_q[6]),
    .sat_i   (sat_q),
    .sig_o   (rnd_sig_s),
    .exp_o   (rnd_exp_s),
    .ovf_o   (rnd_ovf_s)
  );

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sat_d       = sat_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[IN_W-1];
          mag_d   = abs_s;
          exp_d   = EXP_MAX;
          sat_d   = 1'b0;
          state_d = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mag_q[11]) begin
          sat_d   = 1'b1;
          state_d = ST_ROUND;
        end else if (mag_q[10] || (exp_q == 3'd0)) begin
          // Normalised, or exponent floor reached (covers zero input).
          state_d = ST_ROUND;
        end else begin
          mag_d   = {mag_q[IN_W-2:0], 1'b0};
          exp_d   = exp_q - 3'd1;
          state_d = ST_NORM;
        end
      end
      ST_ROUND: begin
        out_sign_d = sign_q;
        out_exp_d  = rnd_exp_s;
        out_sig_d  = rnd_sig_s;
        out_ovf_d  = rnd_ovf_s;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        // out_valid is raised one clock after entering DONE, so the
        // handshake only completes once valid is actually visible.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 12'd0;
      exp_q       <= 3'd0;
      sat_q       <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= 3'd0;
      out_sig_q   <= 4'd0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sat_q       <= sat_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_convert_ctrl
// Directed bench for fp_convert_ctrl; expectations follow FP_CONV_ROUND_EN.
// ---------------------------------------------------------------------------
module tb_fp_convert_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  fp_convert_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Present a sample, wait for the result, check it and its latency, consume it.
  task automatic run(input string tag, input logic [11:0] d, input logic es,
                     input logic [2:0] ee, input logic [3:0] esg, input logic eo,
                     input int elat);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_sign"}, {31'd0, out_sign}, {31'd0, es});
    chk({tag, "_exp"},  {29'd0, out_exp},  {29'd0, ee});
    chk({tag, "_sig"},  {28'd0, out_sig},  {28'd0, esg});
    chk({tag, "_ovf"},  {31'd0, out_ovf},  {31'd0, eo});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_data   = 12'h000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sign",  {31'd0, out_sign},  32'd0);
    chk("rst_out_exp",   {29'd0, out_exp},   32'd0);
    chk("rst_out_sig",   {28'd0, out_sig},   32'd0);
    chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("zero",  12'h000, 1'b0, 3'd0, 4'b0000, 1'b0, 10);
    run("p422",  12'h1A6, 1'b0, 3'd5, 4'b1101, 1'b0, 5);
`ifdef FP_CONV_ROUND_EN
    run("x0f8",  12'h0F8, 1'b0, 3'd5, 4'b1000, 1'b0, 6);
    run("x7ff",  12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b1, 3);
`else
    run("x0f8",  12'h0F8, 1'b0, 3'd4, 4'b1111, 1'b0, 6);
    run("x7ff",  12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b0, 3);
`endif
    run("m2048", 12'h800, 1'b1, 3'd7, 4'b1111, 1'b1, 3);
    run("m1",    12'hFFF, 1'b1, 3'd0, 4'b0001, 1'b0, 10);

    // Back-pressure: result held for 5 clocks while a new sample is offered.
    @(negedge clk);
    in_data  = 12'h1A6;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data  = 12'h800;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid",    {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready},  32'd0);
      chk("bp_exp",      {29'd0, out_exp},   32'd5);
      chk("bp_sig",      {28'd0, out_sig},   32'hD);
      chk("bp_ovf",      {31'd0, out_ovf},   32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("bp_ignored_idle",  {31'd0, in_ready},  32'd1);
    chk("bp_ignored_valid", {31'd0, out_valid}, 32'd0);

    // out_ready already high: result consumed in the cycle valid rises.
    @(negedge clk);
    out_ready = 1'b1;
    in_data   = 12'h800;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("eager_valid", {31'd0, out_valid}, 32'd1);
    chk("eager_sign",  {31'd0, out_sign},  32'd1);
    @(posedge clk); #1;
    chk("eager_consumed", {31'd0, out_valid}, 32'd0);
    chk("eager_idle",     {31'd0, in_ready},  32'd1);
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of normalisation.
    @(negedge clk);
    in_data  = 12'h000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sign",     {31'd0, out_sign},  32'd0);
    chk("mid_rst_exp",      {29'd0, out_exp},   32'd0);
    chk("mid_rst_sig",      {28'd0, out_sig},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 12'h1A6, 1'b0, 3'd5, 4'b1101, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
